// File: rtl/mult_32bit_seq.sv
// Unsigned 32x32 -> 64-bit shift-and-add multiplier built around one ripple adder.
// One iteration per clock; the accumulator's upper half feeds the adder each cycle.

module adder_32bit (
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        carry_in,
   output logic [31:0] sum,
   output logic        cout
);

   assign {cout, sum} = {1'b0, a} + {1'b0, b} + {32'h0, carry_in};

endmodule

module mult_32bit_seq #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [5:0] LAST_CNT = 6'(WIDTH);

   state_t               state;
   logic [WIDTH-1:0]     mcand;
   logic [2*WIDTH-1:0]   acc;
   logic [5:0]           cnt;
   logic [WIDTH-1:0]     add_b;
   logic [WIDTH-1:0]     sum;
   logic                 cout;

   // Multiplier bit currently in acc[0] selects whether the multiplicand is added.
   assign add_b = acc[0] ? mcand : '0;

   adder_32bit u_adder (
      .a        (acc[2*WIDTH-1:WIDTH]),
      .b        (add_b),
      .carry_in (1'b0),
      .sum      (sum),
      .cout     (cout)
   );

   // After 32 iterations (cnt reaches 32) one more CALC cycle publishes acc,
   // so done and the new product appear together and the DONE cycle is the pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         mcand   <= '0;
         acc     <= '0;
         cnt     <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         product <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  mcand <= a;
                  acc   <= {{WIDTH{1'b0}}, b};
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= CALC;
               end
            end
            CALC: begin
               if (cnt == LAST_CNT) begin
                  product <= acc;
                  done    <= 1'b1;
                  state   <= DONE;
               end else begin
                  acc <= {cout, sum, acc[WIDTH-1:1]};
                  cnt <= cnt + 6'd1;
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
